// File: rtl/uart_tx_scheduler.sv
// Round-robin arbiter feeding an 8N1 UART transmitter.
// Shares one tx line between NUM_REQ byte producers.
//
// Ports:
//   clk        system clock
//   arst       asynchronous reset, active-high
//   tick       oversample strobe (OVERSAMPLE pulses per bit)
//   req_valid  per-requester byte available
//   req_data   packed bytes, requester i at [i*DATA_WIDTH +: DATA_WIDTH]
//   req_ready  one-hot acceptance pulse, only in IDLE
//   tx         serial line, idle high, driven from a flop
//   busy       frame in progress (state != IDLE)
//   grant_id   index of the last accepted requester

module uart_tx_scheduler #(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 8,
    parameter int OVERSAMPLE = 16
) (
    input  logic                          clk,
    input  logic                          arst,
    input  logic                          tick,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
    output logic [NUM_REQ-1:0]            req_ready,
    output logic                          tx,
    output logic                          busy,
    output logic [$clog2(NUM_REQ)-1:0]    grant_id
);

    localparam int IDW = $clog2(NUM_REQ);
    localparam int CW  = $clog2(OVERSAMPLE);
    localparam int BW  = $clog2(DATA_WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

    state_t                state_q, state_d;
    logic [IDW-1:0]        ptr_q, ptr_d;
    logic [IDW-1:0]        grant_q, grant_d;
    logic [IDW-1:0]        win;
    logic                  found;
    logic [DATA_WIDTH-1:0] win_data;
    logic [DATA_WIDTH-1:0] sh_q, sh_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic [BW-1:0]         idx_q, idx_d;
    logic                  tx_q, tx_d;
    logic                  busy_q;
    logic                  accept;
    logic                  bit_end;

    // Search upward from the pointer with wrap-around.
    always_comb begin
        int j;
        j        = 0;
        win      = '0;
        found    = 1'b0;
        win_data = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            j = int'(ptr_q) + i;
            if (j >= NUM_REQ) begin
                j = j - NUM_REQ;
            end
            if (!found && req_valid[j]) begin
                found    = 1'b1;
                win      = IDW'(j);
                win_data = req_data[j*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    // Ready is combinational so a requester sees it in the accept cycle;
    // it is masked while reset is held so nothing is accepted then.
    assign accept    = (state_q == IDLE) && found && !arst;
    assign req_ready = accept ? (NUM_REQ'(1) << win) : '0;

    assign bit_end = tick && (cnt_q == CW'(OVERSAMPLE - 1));

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        grant_d = grant_q;
        sh_d    = sh_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        tx_d    = 1'b1;

        case (state_q)
            IDLE: begin
                // A tick in the accept cycle is dropped: counter restarts.
                if (accept) begin
                    state_d = START;
                    sh_d    = win_data;
                    grant_d = win;
                    cnt_d   = '0;
                    idx_d   = '0;
                    if (win == IDW'(NUM_REQ - 1)) begin
                        ptr_d = '0;
                    end else begin
                        ptr_d = win + 1'b1;
                    end
                end
            end
            START: begin
                if (tick) begin
                    cnt_d = bit_end ? '0 : cnt_q + 1'b1;
                end
                if (bit_end) begin
                    state_d = DATA;
                end
            end
            DATA: begin
                if (tick) begin
                    cnt_d = bit_end ? '0 : cnt_q + 1'b1;
                end
                if (bit_end) begin
                    sh_d  = sh_q >> 1;
                    idx_d = idx_q + 1'b1;
                    if (idx_q == BW'(DATA_WIDTH - 1)) begin
                        state_d = STOP;
                    end
                end
            end
            STOP: begin
                if (tick) begin
                    cnt_d = bit_end ? '0 : cnt_q + 1'b1;
                end
                if (bit_end) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
                idx_d   = '0;
            end
        endcase

        // tx is precomputed from the next state so the pin is a flop.
        case (state_d)
            START:   tx_d = 1'b0;
            DATA:    tx_d = sh_d[0];
            default: tx_d = 1'b1;
        endcase
    end

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            grant_q <= '0;
            sh_q    <= '0;
            cnt_q   <= '0;
            idx_q   <= '0;
            tx_q    <= 1'b1;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            grant_q <= grant_d;
            sh_q    <= sh_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            tx_q    <= tx_d;
            busy_q  <= (state_d != IDLE);
        end
    end

    assign tx       = tx_q;
    assign busy     = busy_q;
    assign grant_id = grant_q;

endmodule
